// File: rtl/fetch_ctrl_if.sv
// Fetch unit bus bundle: imem request/response, decode-stage handshake and redirect.
// master = fetch_ctrl view, slave = memory/decode/branch-unit view.
interface fetch_ctrl_if;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_resp_valid_i;
   logic [31:0] imem_resp_data_i;
   logic        imem_resp_err_i;
   logic        inst_valid_o;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_fault_o;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;

   modport master (
      output imem_req_valid_o, imem_req_addr_o,
      input  imem_req_ready_i,
      input  imem_resp_valid_i, imem_resp_data_i, imem_resp_err_i,
      output inst_valid_o, inst_o, inst_pc_o, inst_fault_o,
      input  inst_ready_i,
      input  redirect_i, redirect_pc_i
   );

   modport slave (
      input  imem_req_valid_o, imem_req_addr_o,
      output imem_req_ready_i,
      output imem_resp_valid_i, imem_resp_data_i, imem_resp_err_i,
      input  inst_valid_o, inst_o, inst_pc_o, inst_fault_o,
      output inst_ready_i,
      output redirect_i, redirect_pc_i
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: one imem request per instruction,
// result held for decode until consumed; redirects override everything except BOOT.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned XLEN     = 32
) (
   input logic          clk_i,
   input logic          rst_i,
   fetch_ctrl_if.master bus
);

   typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, FLUSH} state_e;

   state_e            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   inst_q, inst_d;
   logic [XLEN-1:0]   ipc_q, ipc_d;
   logic              fault_q, fault_d;
   logic              req_valid;
   logic              inst_valid;
   logic              misaligned;

   assign misaligned = (pc_q[1:0] != 2'b00);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         ipc_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      ipc_d      = ipc_q;
      fault_d    = fault_q;
      req_valid  = 1'b0;
      inst_valid = 1'b0;

      case (state_q)
         BOOT: state_d = REQ;

         REQ: begin
            req_valid = !misaligned;
            if (bus.redirect_i) begin
               pc_d = bus.redirect_pc_i;
               // an accepted request still owes us a response, which must be skipped
               if (req_valid && bus.imem_req_ready_i) state_d = FLUSH;
            end else if (misaligned) begin
               inst_d  = '0;
               ipc_d   = pc_q;
               fault_d = 1'b1;
               state_d = HOLD;
            end else if (bus.imem_req_ready_i) begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (bus.redirect_i) pc_d = bus.redirect_pc_i;
            if (bus.imem_resp_valid_i) begin
               if (bus.redirect_i) begin
                  state_d = REQ;
               end else begin
                  inst_d  = bus.imem_resp_err_i ? '0 : bus.imem_resp_data_i;
                  ipc_d   = pc_q;
                  fault_d = bus.imem_resp_err_i;
                  state_d = HOLD;
               end
            end else if (bus.redirect_i) begin
               state_d = FLUSH;
            end
         end

         HOLD: begin
            inst_valid = 1'b1;
            if (bus.redirect_i) begin
               pc_d    = bus.redirect_pc_i;
               state_d = REQ;
            end else if (bus.inst_ready_i) begin
               pc_d    = pc_q + XLEN'(4);
               state_d = REQ;
            end
         end

         FLUSH: begin
            if (bus.redirect_i) pc_d = bus.redirect_pc_i;
            if (bus.imem_resp_valid_i) state_d = REQ;
         end

         default: state_d = BOOT;
      endcase
   end

   assign bus.imem_req_valid_o = req_valid;
   assign bus.imem_req_addr_o  = pc_q;
   assign bus.inst_valid_o     = inst_valid;
   assign bus.inst_o           = inst_q;
   assign bus.inst_pc_o        = ipc_q;
   assign bus.inst_fault_o     = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a transaction-level model.
module tb_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy, rv, rerr, redir, drdy;
   logic [31:0] rdata, rpc;
   int          n_cmp = 0;
   int          n_err = 0;

   // model: pc, whether a request is outstanding, whether its response is to be dropped,
   // and the instruction currently offered to decode
   bit          m_boot, m_out, m_drop, m_held, m_fault;
   logic [31:0] m_pc, m_inst, m_ipc;

   // auto memory responder (random phase)
   bit          auto_mem = 1'b0;
   bit          pend = 1'b0;
   int          pend_dly = 0;
   logic [31:0] pend_addr = '0;

   fetch_ctrl_if bus ();

   assign bus.imem_req_ready_i  = rdy;
   assign bus.imem_resp_valid_i = rv;
   assign bus.imem_resp_data_i  = rdata;
   assign bus.imem_resp_err_i   = rerr;
   assign bus.inst_ready_i      = drdy;
   assign bus.redirect_i        = redir;
   assign bus.redirect_pc_i     = rpc;

   fetch_ctrl #(.RESET_PC(32'h8000_0000), .XLEN(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
   endfunction

   function automatic bit exp_req_valid();
      return !m_boot && !m_held && !m_out && (m_pc[1:0] == 2'b00);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("req_valid", {31'b0, bus.imem_req_valid_o}, {31'b0, exp_req_valid()});
      if (exp_req_valid()) chk("req_addr", bus.imem_req_addr_o, m_pc);
      chk("inst_valid", {31'b0, bus.inst_valid_o}, {31'b0, m_held});
      if (m_held) begin
         chk("inst", bus.inst_o, m_inst);
         chk("inst_pc", bus.inst_pc_o, m_ipc);
         chk("inst_fault", {31'b0, bus.inst_fault_o}, {31'b0, m_fault});
      end
   endtask

   task automatic model_reset();
      m_boot = 1'b1; m_out = 1'b0; m_drop = 1'b0; m_held = 1'b0; m_fault = 1'b0;
      m_pc = 32'h8000_0000; m_inst = '0; m_ipc = '0;
      pend = 1'b0;
   endtask

   task automatic model_update();
      bit hs;
      hs = exp_req_valid() && rdy;
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (m_held) begin
         if (redir) begin
            m_held = 1'b0; m_pc = rpc;
         end else if (drdy) begin
            m_held = 1'b0; m_pc = m_pc + 32'd4;
         end
      end else if (m_out) begin
         if (rv) begin
            if (!m_drop && !redir) begin
               m_held = 1'b1; m_inst = rerr ? 32'd0 : rdata; m_fault = rerr; m_ipc = m_pc;
            end
            m_out = 1'b0; m_drop = 1'b0;
         end else if (redir) begin
            m_drop = 1'b1;
         end
         if (redir) m_pc = rpc;
      end else begin
         if (hs) begin
            m_out = 1'b1; m_drop = redir;
            if (auto_mem) begin
               pend = 1'b1; pend_dly = $urandom_range(0, 3); pend_addr = m_pc;
            end
         end
         if (redir) begin
            m_pc = rpc;
         end else if (m_pc[1:0] != 2'b00) begin
            m_held = 1'b1; m_fault = 1'b1; m_inst = '0; m_ipc = m_pc;
         end
      end
   endtask

   // inputs are set by the caller at the falling edge
   task automatic step();
      #1;
      compare_all();
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      rdy = 0; rv = 0; rerr = 0; redir = 0; drdy = 0; rdata = '0; rpc = '0;
   endtask

   task automatic do_reset(input bit late_resp);
      rst = 1'b1;
      rv  = late_resp;
      rdata = 32'hBAD0_BAD0;
      #1;
      model_reset();
      chk("rst_req_valid", {31'b0, bus.imem_req_valid_o}, 32'd0);
      chk("rst_inst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
      chk("rst_inst", bus.inst_o, 32'd0);
      chk("rst_inst_pc", bus.inst_pc_o, 32'd0);
      chk("rst_fault", {31'b0, bus.inst_fault_o}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      idle();
      @(negedge clk);
      do_reset(1'b0);

      // basic fetch and delivery
      step();
      chk("t35_addr", bus.imem_req_addr_o, 32'h8000_0000);
      chk("t35_req_valid", {31'b0, bus.imem_req_valid_o}, 32'd1);
      rdy = 1; step();
      rdy = 0; rv = 1; rdata = 32'h0000_0013; step();
      rv = 0;
      chk("t35_inst", bus.inst_o, 32'h0000_0013);
      chk("t35_inst_pc", bus.inst_pc_o, 32'h8000_0000);
      drdy = 1; step();
      drdy = 0;
      chk("t35_next_addr", bus.imem_req_addr_o, 32'h8000_0004);

      // decode stall
      rdy = 1; step();
      rdy = 0; rv = 1; rdata = 32'h0040_0113; step();
      rv = 0;
      for (int i = 0; i < 5; i++) step();
      chk("t36_inst_pc", bus.inst_pc_o, 32'h8000_0004);
      drdy = 1; step();
      drdy = 0;
      chk("t36_next_addr", bus.imem_req_addr_o, 32'h8000_0008);

      // redirect while waiting: late response dropped
      rdy = 1; step();
      rdy = 0; redir = 1; rpc = 32'h8000_0100; step();
      redir = 0; rv = 1; rdata = 32'hDEAD_BEEF; step();
      rv = 0;
      chk("t37_inst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
      chk("t37_addr", bus.imem_req_addr_o, 32'h8000_0100);
      rdy = 1; step();
      rdy = 0; rv = 1; rdata = 32'h0010_0093; step();
      rv = 0;
      chk("t37_inst_pc", bus.inst_pc_o, 32'h8000_0100);
      drdy = 1; step();
      drdy = 0;

      // misaligned redirect target
      redir = 1; rpc = 32'h8000_0102; step();
      redir = 0;
      chk("t38_no_req", {31'b0, bus.imem_req_valid_o}, 32'd0);
      step();
      chk("t38_fault", {31'b0, bus.inst_fault_o}, 32'd1);
      chk("t38_inst", bus.inst_o, 32'd0);
      chk("t38_inst_pc", bus.inst_pc_o, 32'h8000_0102);
      redir = 1; rpc = 32'h8000_0200; step();
      redir = 0;

      // bus error
      rdy = 1; step();
      rdy = 0; rv = 1; rerr = 1; rdata = 32'h1234_5678; step();
      rv = 0; rerr = 0;
      chk("t39_fault", {31'b0, bus.inst_fault_o}, 32'd1);
      chk("t39_inst", bus.inst_o, 32'd0);
      drdy = 1; step();
      drdy = 0;
      chk("t39_next_addr", bus.imem_req_addr_o, 32'h8000_0204);

      // pc wrap-around, then reset in WAIT with a late response and a BOOT redirect
      redir = 1; rpc = 32'hFFFF_FFFC; step();
      redir = 0; rdy = 1; step();
      rdy = 0; rv = 1; rdata = 32'h0000_AAAA; step();
      rv = 0;
      chk("t40_inst_pc", bus.inst_pc_o, 32'hFFFF_FFFC);
      drdy = 1; step();
      drdy = 0;
      chk("t40_wrap_addr", bus.imem_req_addr_o, 32'h0000_0000);
      rdy = 1; step();
      rdy = 0;
      do_reset(1'b1);
      redir = 1; rpc = 32'h0000_1234; step();
      redir = 0; step();
      rv = 0;
      chk("t40_boot_addr", bus.imem_req_addr_o, 32'h8000_0000);
      chk("t40_boot_inst_valid", {31'b0, bus.inst_valid_o}, 32'd0);
      rdy = 1; step();
      rdy = 0; rv = 1; rdata = 32'h0000_0013; step();
      rv = 0;
      chk("t40_boot_inst_pc", bus.inst_pc_o, 32'h8000_0000);
      drdy = 1; step();
      idle();

      // randomized traffic
      auto_mem = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         logic [31:0] r;
         rdy  = ($urandom_range(0, 9) < 6);
         drdy = ($urandom_range(0, 9) < 6);
         redir = ($urandom_range(0, 99) < 8);
         r = $urandom;
         case ($urandom_range(0, 7))
            0:       rpc = r;
            1:       rpc = 32'hFFFF_FFF8 + {29'd0, r[0], 2'b00};
            default: rpc = {r[31:2], 2'b00};
         endcase
         rv = 1'b0; rerr = 1'b0; rdata = r;
         if (pend) begin
            if (pend_dly == 0) begin
               rv = 1'b1; rdata = mem_word(pend_addr); rerr = ($urandom_range(0, 9) == 0);
               pend = 1'b0;
            end else begin
               pend_dly--;
            end
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, meaning the address of the first fetch after reset.
REQ-002 Parameter XLEN, default 32, meaning the PC and instruction width; only 32 is supported.
REQ-003 clk_i  input  1  clock; all state changes occur on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 imem_req_valid_o  output  1  fetch request valid.
REQ-006 imem_req_ready_i  input  1  imem accepts the request this cycle.
REQ-007 imem_req_addr_o  output  32  fetch address (current PC).
REQ-008 imem_resp_valid_i  input  1  response valid; exactly one response per accepted request, in order, at least 1 cycle after acceptance.
REQ-009 imem_resp_data_i  input  32  fetched instruction word.
REQ-010 imem_resp_err_i  input  1  bus error for this response.
REQ-011 inst_valid_o  output  1  instruction valid to the decode stage.
REQ-012 inst_ready_i  input  1  decode stage consumes the instruction this cycle.
REQ-013 inst_o  output  32  instruction word.
REQ-014 inst_pc_o  output  32  PC of inst_o.
REQ-015 inst_fault_o  output  1  fetch fault (bus error or misaligned PC); inst_o = 0 when set.
REQ-016 redirect_i  input  1  next-PC override (taken branch, jal, jalr, trap); single-cycle pulse.
REQ-017 redirect_pc_i  input  32  redirect target.

Function
REQ-018 The FSM states SHALL be BOOT, REQ, WAIT, HOLD and FLUSH; imem_req_valid_o = 1 only in REQ; inst_valid_o = 1 only in HOLD.
REQ-019 BOOT -> REQ on the first rising edge with rst_i low; no other activity in BOOT.
REQ-020 REQ: on imem_req_valid_o && imem_req_ready_i -> WAIT; otherwise stay; imem_req_addr_o = pc, held stable while waiting for ready.
REQ-021 REQ with pc[1:0] != 0: no request is issued; -> HOLD with inst_fault_o = 1, inst_o = 0, inst_pc_o = pc.
REQ-022 WAIT: on imem_resp_valid_i, capture inst_o = err ? 0 : data, inst_fault_o = err, inst_pc_o = pc; -> HOLD; outputs registered, so inst_valid_o rises the cycle after the response.
REQ-023 HOLD: inst_o, inst_pc_o and inst_fault_o SHALL be stable until inst_valid_o && inst_ready_i; on that handshake, pc <= pc + 4 (mod 2^32), -> REQ.
REQ-024 Redirect has priority over every other event: pc <= redirect_pc_i in every state except BOOT.
REQ-025 Redirect in REQ with no handshake: the request is withdrawn; stay REQ with the new address next cycle.
REQ-026 Redirect in REQ with a same-cycle handshake: -> FLUSH.
REQ-027 Redirect in WAIT with no response: -> FLUSH.
REQ-028 Redirect in WAIT with a same-cycle response: the response is discarded; -> REQ.
REQ-029 Redirect in HOLD, with or without inst_ready_i: the held instruction is dropped; -> REQ; no +4 increment.
REQ-030 FLUSH: the next response is discarded, with no update to inst_*; -> REQ on its arrival; a further redirect in FLUSH only updates pc.
REQ-031 Minimum latency with zero-wait memory and decode is 3 cycles per instruction (REQ, WAIT, HOLD); no prefetch and no more than one outstanding request.
REQ-032 Redirect in BOOT SHALL be ignored.

Reset
REQ-033 While rst_i is high: state = BOOT, pc = RESET_PC, imem_req_valid_o = 0, inst_valid_o = 0, inst_o = 0, inst_pc_o = 0, inst_fault_o = 0.
REQ-034 Reset asserted mid-transaction SHALL abandon any outstanding request; a response arriving during or after reset, before a new request, SHALL be ignored.

Verification
REQ-035 Reset release, ready = 1, response of 0x00000013 one cycle later -> addr 0x80000000; inst_valid_o with inst_o 0x00000013 and inst_pc_o 0x80000000; next request to 0x80000004.
REQ-036 inst_ready_i held low for 5 cycles in HOLD -> inst_o and inst_pc_o are unchanged, with no new request; ready = 1 -> request at pc + 4.
REQ-037 Redirect to 0x80000100 in WAIT, then a response of 0xDEADBEEF -> the response is dropped (FLUSH); the next request is to 0x80000100 and is delivered with inst_pc_o = 0x80000100.
REQ-038 Redirect to 0x80000102 -> no imem request; inst_valid_o with inst_fault_o = 1, inst_o = 0, inst_pc_o = 0x80000102.
REQ-039 imem_resp_err_i = 1 with data 0x12345678 -> inst_fault_o = 1, inst_o = 0; after the handshake, fetch continues at pc + 4.
REQ-040 PC 0xFFFFFFFC delivered and consumed -> next request address 0x00000000 (wrap-around); rst_i pulsed in WAIT -> BOOT, with the late response ignored and the first request to 0x80000000.
